// File: rtl/trc_pkg.sv
// Shared definitions for the instruction trace buffer and its console decode.
//   - trc_entry_t: one captured fetch, {PC, IR}, in big-endian bit numbering
//   - head_st_e:   state of the registered show-ahead head path
//   - bit positions of the trITR status word and the trPCIR head word
//   - itr_pack():  assembles a trITR status word from its fields
package trc_pkg;

  localparam int unsigned DefaultDepthLog2 = 10;

  typedef struct packed {
    logic [0:17] pc;
    logic [0:35] ir;
  } trc_entry_t;

  localparam int unsigned EntryW = $bits(trc_entry_t);

  // Head path: no head and no read in flight / RAM read in flight / head valid.
  typedef enum logic [1:0] {
    HdIdle,
    HdLoad,
    HdValid
  } head_st_e;

  // trITR bit positions (bit 0 is the MSB).
  localparam int unsigned ItrEmpty  = 0;
  localparam int unsigned ItrFull   = 1;
  localparam int unsigned ItrOvf    = 2;
  localparam int unsigned ItrEn     = 3;
  localparam int unsigned ItrCntMsb = 16;
  localparam int unsigned ItrCntLsb = 31;

  // trPCIR: the entry occupies [10:63], PC in [10:27], IR in [28:63].
  localparam int unsigned PcirPcMsb = 10;
  localparam int unsigned PcirIrLsb = 63;

  function automatic logic [0:63] itr_pack(logic empty, logic full, logic ovf, logic en,
                                           logic [15:0] cnt);
    logic [0:63] v;
    v = '0;
    v[ItrEmpty] = empty;
    v[ItrFull]  = full;
    v[ItrOvf]   = ovf;
    v[ItrEn]    = en;
    v[ItrCntMsb:ItrCntLsb] = cnt;
    return v;
  endfunction

endpackage

// File: rtl/trc_ram.sv
// Simple dual-port synchronous RAM for trace entries.
//   clk          clock
//   we/waddr/wdata  write port, written on the rising edge when we=1
//   re/raddr     read port; rdata is registered and updates only when re=1
//   rdata        read data
// The array has no reset. Callers never read and write the same address on one edge.
module trc_ram #(
  parameter int unsigned Width = 54,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trc_buffer.sv
// Instruction trace buffer (TR side of the console/trace link).
// Captures {PC, IR} on each CPU fetch into a FIFO and presents the oldest entry with status.
//   clk, rst      clock; synchronous active-high reset
//   cpuFETCH      one-cycle fetch strobe; cpuPC / cpuIR are captured with it
//   trEN          capture enable
//   trCLR         clear pointers, count, overflow and head (RAM untouched)
//   trADV         pop the head entry
//   trITR         registered status: empty, full, overflow, trEN echo, entry count
//   trPCIR        registered head entry, zero while empty
module trc_buffer
  import trc_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuFETCH,
  input  logic [0:17] cpuPC,
  input  logic [0:35] cpuIR,
  input  logic        trEN,
  input  logic        trCLR,
  input  logic        trADV,
  output logic [0:63] trITR,
  output logic [0:63] trPCIR
);

  localparam int unsigned CntW = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] FullCnt = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  head_st_e              hd_st_q, hd_st_d;
  logic [0:63]           itr_q, itr_d, pcir_q, pcir_d;

  logic       full, adv_fire, push, drop, rd_en, ram_we;
  trc_entry_t wr_entry, rd_entry;

  assign wr_entry = '{pc: cpuPC, ir: cpuIR};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    hd_st_d = hd_st_q;
    pcir_d  = pcir_q;
    rd_en   = 1'b0;

    full     = (cnt_q == FullCnt);
    adv_fire = trADV && (hd_st_q == HdValid);
    // A pop in the same cycle frees the slot, so a full buffer still accepts the capture.
    push     = cpuFETCH && trEN && (!full || adv_fire);
    drop     = cpuFETCH && trEN && full && !adv_fire;

    unique case (hd_st_q)
      HdIdle: begin
        // With no head, every counted entry is unread in RAM.
        if (cnt_q != '0) begin
          rd_en   = 1'b1;
          hd_st_d = HdLoad;
        end
      end
      HdLoad: begin
        hd_st_d = HdValid;
        pcir_d  = '0;
        pcir_d[PcirPcMsb:PcirIrLsb] = rd_entry;
      end
      HdValid: begin
        if (adv_fire) begin
          pcir_d = '0;
          // cnt_q - 1 entries remain unread; prefetch now so the next head lands one clock later.
          // An entry pushed on this same edge is not yet in RAM; HdIdle picks it up.
          if (cnt_q > OneCnt) begin
            rd_en   = 1'b1;
            hd_st_d = HdLoad;
          end else begin
            hd_st_d = HdIdle;
          end
        end
      end
      default: hd_st_d = HdIdle;
    endcase

    if (rd_en) rptr_d = rptr_q + DEPTH_LOG2'(1);
    if (push)  wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (drop)  ovf_d  = 1'b1;
    cnt_d = cnt_q + CntW'(push) - CntW'(adv_fire);

    if (trCLR) begin
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      hd_st_d = HdIdle;
      pcir_d  = '0;
      rd_en   = 1'b0;
    end

    // Status is built from next-state so it moves on the same edge as the pointers.
    itr_d = itr_pack(hd_st_d != HdValid, cnt_d == FullCnt, ovf_d, trEN, 16'(cnt_d));
  end

  assign ram_we = push && !trCLR && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hd_st_q <= HdIdle;
      pcir_q  <= '0;
      itr_q   <= itr_pack(1'b1, 1'b0, 1'b0, trEN, 16'h0000);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hd_st_q <= hd_st_d;
      pcir_q  <= pcir_d;
      itr_q   <= itr_d;
    end
  end

  trc_ram #(
    .Width(EntryW),
    .AddrW(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wptr_q),
    .wdata(wr_entry),
    .re   (rd_en && !rst),
    .raddr(rptr_q),
    .rdata(rd_entry)
  );

  assign trITR  = itr_q;
  assign trPCIR = pcir_q;

endmodule

// File: tb/tb_trc_buffer.sv
// Self-checking bench for trc_buffer (DEPTH_LOG2 = 4).
// A queue-based model predicts trITR/trPCIR every cycle; directed steps add literal checks.
module tb_trc_buffer;

  localparam int unsigned DL = 4;
  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpuFETCH = 1'b0;
  logic [0:17] cpuPC = '0;
  logic [0:35] cpuIR = '0;
  logic        trEN = 1'b0;
  logic        trCLR = 1'b0;
  logic        trADV = 1'b0;
  logic [0:63] trITR, trPCIR;

  int checks = 0;
  int errors = 0;

  trc_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk     (clk),
    .rst     (rst),
    .cpuFETCH(cpuFETCH),
    .cpuPC   (cpuPC),
    .cpuIR   (cpuIR),
    .trEN    (trEN),
    .trCLR   (trCLR),
    .trADV   (trADV),
    .trITR   (trITR),
    .trPCIR  (trPCIR)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Each entry remembers the edge that wrote it. The head is visible once it is two edges
  // old and at least one edge has passed since the previous pop.
  typedef struct {
    logic [0:17] pc;
    logic [0:35] ir;
    int          wc;
  } ment_t;

  ment_t q[$];
  int    edge_n   = 0;
  int    last_pop = -100;
  bit    m_ovf    = 0;
  bit    m_en     = 0;
  bit    m_live   = 0;

  function automatic bit m_vis(int c);
    if (q.size() == 0) return 1'b0;
    return (c >= q[0].wc + 2) && (c >= last_pop + 1);
  endfunction

  function automatic logic [0:63] m_itr();
    logic [0:63] v;
    v = '0;
    v[0] = !m_vis(edge_n);
    v[1] = (q.size() == Depth);
    v[2] = m_ovf;
    v[3] = m_en;
    v[16:31] = 16'(q.size());
    return v;
  endfunction

  function automatic logic [0:63] m_pcir();
    logic [0:63] v;
    v = '0;
    if (m_vis(edge_n)) v[10:63] = {q[0].pc, q[0].ir};
    return v;
  endfunction

  always @(posedge clk) begin
    bit vis, adv_ok, full;
    vis = m_vis(edge_n);
    edge_n++;
    if (rst || trCLR) begin
      q.delete();
      m_ovf    = 1'b0;
      last_pop = -100;
      if (rst) m_live = 1'b1;
    end else begin
      full   = (q.size() == Depth);
      adv_ok = trADV && vis;
      if (adv_ok) begin
        void'(q.pop_front());
        last_pop = edge_n;
      end
      if (cpuFETCH && trEN) begin
        if (!full || adv_ok) q.push_back('{cpuPC, cpuIR, edge_n});
        else m_ovf = 1'b1;
      end
    end
    m_en = trEN;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("trITR", trITR, m_itr());
      chk("trPCIR", trPCIR, m_pcir());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit f = 1'b0, logic [0:17] pc = '0, bit a = 1'b0, bit c = 1'b0,
                     bit r = 1'b0);
    cpuFETCH = f;
    cpuPC    = pc;
    cpuIR    = {~pc, pc};
    trADV    = a;
    trCLR    = c;
    rst      = r;
    @(posedge clk);
    #1;
    cpuFETCH = 1'b0;
    trADV    = 1'b0;
    trCLR    = 1'b0;
    rst      = 1'b0;
  endtask

  function automatic logic [63:0] cnt();
    return 64'(trITR[16:31]);
  endfunction

  function automatic logic [63:0] hpc();
    return 64'(trPCIR[10:27]);
  endfunction

  initial begin
    logic [63:0] last;
    int          maxc;
    logic [0:17] exp_pc [3];
    exp_pc[0] = 18'o101;
    exp_pc[1] = 18'o102;
    exp_pc[2] = 18'o0;

    // 1. reset, three fetches, three spaced advances
    trEN = 1'b1;
    cyc(.r(1'b1));
    chk("rst_itr", trITR, 64'h9000_0000_0000_0000);
    chk("rst_pcir", trPCIR, 64'h0);
    cyc(1'b1, 18'o100);
    cyc(1'b1, 18'o101);
    cyc(1'b1, 18'o102);
    cyc();
    chk("t1_cnt", cnt(), 64'd3);
    chk("t1_empty", 64'(trITR[0]), 64'd0);
    chk("t1_pc0", hpc(), 64'o100);
    chk("t1_ir0", 64'(trPCIR[28:63]), 64'o777677000100);
    for (int i = 0; i < 3; i++) begin
      cyc(.a(1'b1));
      cyc();
      chk("t1_pc_adv", hpc(), 64'(exp_pc[i]));
    end
    chk("t1_drained_itr", trITR, 64'h9000_0000_0000_0000);
    chk("t1_drained_pcir", trPCIR, 64'h0);

    // 2. fill to full, then overflow
    cyc(.c(1'b1));
    for (int i = 0; i < 16; i++) cyc(1'b1, 18'(18'o200 + i));
    cyc();
    chk("t2_full", 64'(trITR[1]), 64'd1);
    chk("t2_cnt", cnt(), 64'd16);
    chk("t2_ovf0", 64'(trITR[2]), 64'd0);
    cyc(1'b1, 18'o777);
    chk("t2_ovf1", 64'(trITR[2]), 64'd1);
    chk("t2_cnt17", cnt(), 64'd16);
    chk("t2_head", hpc(), 64'o200);

    // 3. simultaneous capture + advance while full
    cyc(.c(1'b1));
    for (int i = 0; i < 16; i++) cyc(1'b1, 18'(18'o300 + i));
    cyc();
    cyc(1'b1, 18'o400, 1'b1);
    chk("t3_cnt", cnt(), 64'd16);
    chk("t3_ovf", 64'(trITR[2]), 64'd0);
    cyc();
    chk("t3_next", hpc(), 64'o301);
    last = '0;
    for (int i = 0; i < 16; i++) begin
      last = hpc();
      cyc(.a(1'b1));
      cyc();
    end
    chk("t3_last", last, 64'o400);
    chk("t3_empty", 64'(trITR[0]), 64'd1);

    // 4. wrap-around with interleaved fetch/advance
    cyc(.c(1'b1));
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 18'(18'o1000 + i));
      if (int'(cnt()) > maxc) maxc = int'(cnt());
      cyc();
      cyc();
      chk("t4_order", hpc(), 64'(18'o1000 + i));
      cyc(.a(1'b1));
      if (int'(cnt()) > maxc) maxc = int'(cnt());
    end
    chk("t4_maxcnt", 64'(maxc), 64'd1);

    // 5. clear priority over fetch and advance
    cyc(.c(1'b1));
    for (int i = 0; i < 5; i++) cyc(1'b1, 18'(18'o500 + i));
    cyc();
    cyc(1'b1, 18'o555, 1'b1, 1'b1);
    chk("t5_itr", trITR, 64'h9000_0000_0000_0000);
    chk("t5_pcir", trPCIR, 64'h0);
    repeat (3) cyc();
    chk("t5_stay", trITR, 64'h9000_0000_0000_0000);

    // 6. enable gating, empty advance, no flush on disable, mid-stream reset
    trEN = 1'b0;
    cyc(.c(1'b1));
    for (int i = 0; i < 4; i++) cyc(1'b1, 18'(18'o700 + i));
    cyc();
    chk("t6_disabled", trITR, 64'h8000_0000_0000_0000);
    cyc(.a(1'b1));
    chk("t6_empty_adv", trITR, 64'h8000_0000_0000_0000);
    trEN = 1'b1;
    cyc(1'b1, 18'o600);
    cyc(1'b1, 18'o601);
    cyc();
    trEN = 1'b0;
    cyc();
    chk("t6_keep_pc", hpc(), 64'o600);
    chk("t6_keep_cnt", cnt(), 64'd2);
    chk("t6_en_echo", 64'(trITR[3]), 64'd0);
    cyc(.a(1'b1));
    cyc();
    chk("t6_keep_pc2", hpc(), 64'o601);
    trEN = 1'b1;
    cyc(1'b1, 18'o602);
    cyc(.r(1'b1));
    chk("t6_rst_itr", trITR, 64'h9000_0000_0000_0000);
    chk("t6_rst_pcir", trPCIR, 64'h0);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
